// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory stage:
//   - state_e  : data-memory request FSM states
//   - bcond_e  : branch condition codes evaluated against the flag register
//   - bit indices into the M control bundle {Branch, MemWrite, MemRead}
//   - bit indices into the WB control bundle {MemToReg, RegWrite}
//   - bit indices into the flag vector {zr, neg, ov}
//   - is_mem_op() helper: true when an M bundle requests a memory access
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    BC_NE = 3'b000,
    BC_EQ = 3'b001,
    BC_GT = 3'b010,
    BC_LT = 3'b011,
    BC_GE = 3'b100,
    BC_LE = 3'b101,
    BC_OV = 3'b110,
    BC_AL = 3'b111
  } bcond_e;

  // M bundle bit positions
  localparam int MEM_READ  = 0;
  localparam int MEM_WRITE = 1;
  localparam int BRANCH    = 2;

  // WB bundle bit positions
  localparam int REG_WRITE  = 0;
  localparam int MEM_TO_REG = 1;

  // Flag vector bit positions
  localparam int FLAG_OV  = 0;
  localparam int FLAG_NEG = 1;
  localparam int FLAG_ZR  = 2;

  function automatic logic is_mem_op(input logic [2:0] m);
    return m[MEM_READ] | m[MEM_WRITE];
  endfunction

endpackage : mem_pkg

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational evaluation of a branch condition code against a
// flag vector. Kept separate so early-branch logic can reuse it.
// Ports:
//   bcond  in  3  condition code (see mem_pkg::bcond_e)
//   flags  in  3  {zr, neg, ov}
//   taken  out 1  condition holds
// -----------------------------------------------------------------------------
module branch_cond_eval
  import mem_pkg::*;
(
  input  logic [2:0] bcond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic zr;
  logic neg;
  logic ov;

  assign zr  = flags[FLAG_ZR];
  assign neg = flags[FLAG_NEG];
  assign ov  = flags[FLAG_OV];

  always_comb begin
    taken = 1'b0;
    unique case (bcond_e'(bcond))
      BC_NE:   taken = ~zr;
      BC_EQ:   taken = zr;
      BC_GT:   taken = ~zr & ~neg;
      BC_LT:   taken = neg;
      BC_GE:   taken = zr | ~neg;
      BC_LE:   taken = neg | zr;
      BC_OV:   taken = ov;
      BC_AL:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule : branch_cond_eval

// File: rtl/mem_slice.sv
// -----------------------------------------------------------------------------
// mem_slice
// Memory stage sitting directly after execute. Holds the EX/MEM pipeline
// latch, the architectural flag register, branch resolution and the
// data-memory request FSM (ack handshake with timeout to a sticky error).
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   valid_in, WB_in, M_in, wreg_in, flag_we_in,
//   addr_in, data_in, result_in, flags_in, PCbranch_in, bcond_in
//                                 execute-stage outputs captured into the latch
//   mem_addr, mem_wdata, mem_re, mem_we   data-memory request
//   mem_rdata, mem_ack                    data-memory response
//   wb_valid, wb_regwrite, wb_reg, wb_data  write-back interface
//   branch_taken, branch_target           fetch redirect / flush
//   flags_q                               architectural flags {zr, neg, ov}
//   mem_stall                             hold all upstream stages
//   mem_err                               sticky timeout error
// -----------------------------------------------------------------------------
module mem_slice
  import mem_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [1:0]    WB_in,
  input  logic [2:0]    M_in,
  input  logic [3:0]    wreg_in,
  input  logic          flag_we_in,
  input  logic [DW-1:0] addr_in,
  input  logic [DW-1:0] data_in,
  input  logic [DW-1:0] result_in,
  input  logic [2:0]    flags_in,
  input  logic [DW-1:0] PCbranch_in,
  input  logic [2:0]    bcond_in,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          wb_valid,
  output logic          wb_regwrite,
  output logic [3:0]    wb_reg,
  output logic [DW-1:0] wb_data,
  output logic          branch_taken,
  output logic [DW-1:0] branch_target,
  output logic [2:0]    flags_q,
  output logic          mem_stall,
  output logic          mem_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // EX/MEM latch
  logic          valid_q,    valid_d;
  logic [1:0]    wb_q,       wb_d;
  logic [2:0]    m_q,        m_d;
  logic [3:0]    wreg_q,     wreg_d;
  logic [DW-1:0] addr_q,     addr_d;
  logic [DW-1:0] data_q,     data_d;
  logic [DW-1:0] result_q,   result_d;
  logic [DW-1:0] pcbranch_q, pcbranch_d;
  logic [2:0]    bcond_q,    bcond_d;
  logic [2:0]    flags_d;

  // Request FSM
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic cond_true;
  logic new_valid;
  logic new_mem_op;

  branch_cond_eval u_cond (
    .bcond (bcond_q),
    .flags (flags_q),
    .taken (cond_true)
  );

  assign branch_taken  = valid_q & m_q[BRANCH] & cond_true;
  assign branch_target = pcbranch_q;

  // The instruction arriving on the redirect edge is younger than the branch
  // and must be squashed.
  assign new_valid  = valid_in & ~branch_taken;
  assign new_mem_op = new_valid & is_mem_op(M_in);

  // Latch next-value: load everything whenever the stage is not stalled.
  // Flags follow the captured instruction, so a squashed one cannot touch them.
  always_comb begin
    valid_d    = valid_q;
    wb_d       = wb_q;
    m_d        = m_q;
    wreg_d     = wreg_q;
    addr_d     = addr_q;
    data_d     = data_q;
    result_d   = result_q;
    pcbranch_d = pcbranch_q;
    bcond_d    = bcond_q;
    flags_d    = flags_q;
    if (!mem_stall) begin
      valid_d    = new_valid;
      wb_d       = WB_in;
      m_d        = M_in;
      wreg_d     = wreg_in;
      addr_d     = addr_in;
      data_d     = data_in;
      result_d   = result_in;
      pcbranch_d = PCbranch_in;
      bcond_d    = bcond_in;
      if (new_valid && flag_we_in) begin
        flags_d = flags_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      wb_q       <= '0;
      m_q        <= '0;
      wreg_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      result_q   <= '0;
      pcbranch_q <= '0;
      bcond_q    <= '0;
      flags_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      wb_q       <= wb_d;
      m_q        <= m_d;
      wreg_q     <= wreg_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      result_q   <= result_d;
      pcbranch_q <= pcbranch_d;
      bcond_q    <= bcond_d;
      flags_q    <= flags_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state. The state always describes what the latch holds, so an
  // ack that retires one memory op can immediately re-enter ACCESS for the
  // op captured on the same edge. Ack beats the timeout on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (new_mem_op) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = new_mem_op ? ACCESS : IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_stall = 1'b0;
    mem_err   = 1'b0;
    unique case (state_q)
      ACCESS: begin
        mem_re    = m_q[MEM_READ];
        mem_we    = m_q[MEM_WRITE];
        mem_stall = ~mem_ack;
      end
      ERROR: begin
        mem_stall = 1'b1;
        mem_err   = 1'b1;
      end
      default: begin
        mem_stall = 1'b0;
      end
    endcase
    wb_valid    = valid_q & ~((state_q == ACCESS) & ~mem_ack) & (state_q != ERROR);
    wb_regwrite = wb_valid & wb_q[REG_WRITE];
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign wb_reg    = wreg_q;
  assign wb_data   = wb_q[MEM_TO_REG] ? mem_rdata : result_q;

endmodule : mem_slice

// File: doc/mem_slice.md
Name: mem_slice

Overview:
- Memory stage directly downstream of the execute stage. Contains the EX/MEM pipeline register, the architectural flag register, branch resolution, and a data-memory request FSM with ack handshake and timeout.
- Consumes execute-stage outputs: addr, data, result, flags, branch target, bcond, M and WB controls.
- Produces write-back data and control for the WB stage, branch redirect/flush to fetch, and a stall to all upstream stages.

Parameters:
- DW, 16, datapath width
- TIMEOUT, 15, cycles a memory request may remain un-acked before the error state

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- valid_in  in  1  execute stage presents a live instruction
- WB_in  in  2  {MemToReg, RegWrite}
- M_in  in  3  {Branch, MemWrite, MemRead}
- wreg_in  in  4  destination register
- flag_we_in  in  1  instruction updates flags (arithmetic/logic op)
- addr_in, data_in, result_in  in  DW each  execute-stage address, store data, ALU result
- flags_in  in  3  {zr, neg, ov}
- PCbranch_in  in  DW  branch target
- bcond_in  in  3  branch condition code
- mem_addr  out  DW  data-memory address
- mem_wdata  out  DW  store data
- mem_re, mem_we  out  1  read/write request
- mem_rdata  in  DW  read data, valid when mem_ack=1
- mem_ack  in  1  request completes this cycle
- wb_valid  out  1  live instruction to WB
- wb_regwrite  out  1  register-file write enable
- wb_reg  out  4  destination register
- wb_data  out  DW  mem_rdata if MemToReg, else latched result
- branch_taken  out  1  redirect fetch and flush younger instructions
- branch_target  out  DW  latched PCbranch
- flags_q  out  3  architectural flags {zr, neg, ov}
- mem_stall  out  1  hold all upstream stages
- mem_err  out  1  sticky timeout error

Behaviour:
- Reset (rst=0, asynchronous) clears the latch (valid=0), flags_q=0, state=IDLE, counter=0. All outputs are 0 during and after reset until the first capture.
- Capture: on a rising edge with mem_stall=0, the latch loads all *_in values.
  - Captured valid = valid_in & ~branch_taken; an instruction arriving on the redirect edge is squashed.
  - Same edge: if the captured instruction is valid and flag_we_in=1, flags_q <= flags_in.
- Hold: with mem_stall=1 the latch and flags_q hold.
- Branch: branch_taken = valid & Branch & cond(bcond, flags_q); combinational from the latch.
  - Condition codes: 000 NE (!zr), 001 EQ (zr), 010 GT (!zr & !neg), 011 LT (neg), 100 GE (zr | !neg), 101 LE (neg | zr), 110 OV (ov), 111 always.
  - Asserts for exactly one cycle, because branch instructions never stall.
- FSM states:
  - IDLE: no pending memory access.
  - ACCESS: latch holds a valid MemRead or MemWrite.
  - ERROR: terminal.
- mem_re / mem_we = (state==ACCESS) & MemRead / MemWrite. mem_addr and mem_wdata always drive the latched addr and data.
- IDLE -> ACCESS on any capture of a valid memory op.
- In ACCESS:
  - mem_stall = ~mem_ack.
  - On ack, the instruction retires that cycle (wb_valid=1) and the next capture happens at the same edge. Next state is ACCESS if the new instruction is a memory op (counter cleared), else IDLE.
  - A zero-wait memory (ack in the first cycle) therefore costs no stall.
- ACCESS -> IDLE when the captured instruction has no memory op.
- Timeout: the counter increments each un-acked ACCESS cycle. When counter == TIMEOUT-1 with no ack: next state ERROR.
- ERROR: mem_re=mem_we=0, mem_stall=1, mem_err=1, wb_valid=0. Leaves only on reset.
- wb_valid = valid & ~(state==ACCESS & ~mem_ack) & state!=ERROR. wb_regwrite = wb_valid & RegWrite.
- Simultaneous ack and timeout boundary: ack wins; no error.
- Reset mid-access drops the request immediately; no ack is expected after.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, ACCESS, ERROR}
  - bcond enum with the codes above
  - bit-index constants for M (MEM_READ=0, MEM_WRITE=1, BRANCH=2) and WB (REG_WRITE=0, MEM_TO_REG=1)
- Sub-module branch_cond_eval: combinational (bcond, flags) -> taken; reused by any future early-branch logic.

Test Plan:
- Reset during ACCESS with mem_re=1 → all outputs 0 within the same cycle; after release, state IDLE and flags_q=0.
- Load, MemToReg=1, wreg=5, addr=0x0040, ack in first cycle, mem_rdata=0xBEEF → mem_stall never high; wb_valid=1, wb_reg=5, wb_data=0xBEEF.
- Store addr=0x0010 data=0x1234, ack after 3 cycles → mem_we=1 and mem_stall=1 for 3 cycles with the latch held; retires on the 4th cycle with wb_regwrite=0.
- ADD with flag_we=1 and flags_in=3'b100, then BEQ (bcond=001, target=0x0020) → branch_taken=1 for one cycle with branch_target=0x0020; the instruction presented on that edge is captured with valid=0.
- Same sequence with flags_in=3'b000 → branch_taken stays 0; a following NAND with flag_we=1 and flags_in=3'b001 makes flags_q=001, then BOV (110) is taken.
- Load with no ack, TIMEOUT=15 → ERROR after 15 cycles: mem_err=1, mem_re=0, mem_stall stuck at 1 until rst=0; with ack on exactly cycle 15 → normal retire, mem_err stays 0.
